// File: rtl/nios2_oci_monitor_mem.sv
// Clock-side monitor-memory engine for the debug JTAG path: decodes ocimem strobes
// into word reads/writes on a 1-cycle-latency debug RAM and reports data/ready/error.
module nios2_oci_monitor_mem #(
   parameter int ADDR_W    = 8,
   parameter int RAM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_WAIT  = 2'd2,
      WR       = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L  = RAM_DEPTH[ADDR_W:0];
   localparam logic [31:0]     BAD_WORD = 32'hDEADDEAD;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_L);
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
   logic [31:0]         mon_d_q, mon_d_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic                ram_rd_q, ram_rd_d;
   logic                ram_wr_q, ram_wr_d;
   logic [31:0]         ram_wdata_q, ram_wdata_d;
   logic                ready_q, ready_d;
   logic                error_q, error_d;
   logic                oor_q, oor_d;

   logic [ADDR_W-1:0]   load_addr_s;
   logic [ADDR_W-1:0]   inc_addr_s;
   logic                any_strobe_s;
   logic                unused_jdo_s;

   assign load_addr_s  = jdo[17+ADDR_W-1:17];
   assign inc_addr_s   = mon_a_q + ADDR_W'(1);
   assign any_strobe_s = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

   // Next-state, strobe decode and completion handling
   always_comb begin
      state_d     = state_q;
      mon_a_d     = mon_a_q;
      mon_d_d     = mon_d_q;
      ram_addr_d  = ram_addr_q;
      ram_rd_d    = 1'b0;
      ram_wr_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      ready_d     = ready_q;
      error_d     = error_q;
      oor_d       = oor_q;

      case (state_q)
         IDLE: begin
            if (take_action_ocimem_a) begin
               mon_a_d = load_addr_s;
               if (jdo[35]) begin
                  error_d = 1'b0;
               end else begin
                  error_d = error_q;
               end
               if (jdo[34]) begin
                  state_d    = RD_ISSUE;
                  ready_d    = 1'b0;
                  ram_addr_d = load_addr_s;
                  oor_d      = !in_range(load_addr_s);
                  ram_rd_d   = in_range(load_addr_s);
               end else begin
                  ready_d = 1'b1;
               end
            end else if (take_action_ocimem_b) begin
               state_d     = WR;
               ready_d     = 1'b0;
               ram_addr_d  = mon_a_q;
               ram_wdata_d = jdo[34:3];
               oor_d       = !in_range(mon_a_q);
               ram_wr_d    = in_range(mon_a_q);
            end else if (take_no_action_ocimem_a) begin
               mon_a_d    = inc_addr_s;
               state_d    = RD_ISSUE;
               ready_d    = 1'b0;
               ram_addr_d = inc_addr_s;
               oor_d      = !in_range(inc_addr_s);
               ram_rd_d   = in_range(inc_addr_s);
            end else begin
               state_d = IDLE;
            end
         end
         RD_ISSUE: begin
            state_d = RD_WAIT;
            if (any_strobe_s) begin
               error_d = 1'b1;
            end else begin
               error_d = error_q;
            end
         end
         RD_WAIT: begin
            state_d = IDLE;
            ready_d = 1'b1;
            // Out-of-range reads return a marker word instead of RAM data
            if (oor_q) begin
               mon_d_d = BAD_WORD;
               error_d = 1'b1;
            end else begin
               mon_d_d = ram_rdata;
               error_d = error_q | any_strobe_s;
            end
         end
         WR: begin
            state_d = IDLE;
            ready_d = 1'b1;
            mon_a_d = inc_addr_s;
            if (oor_q) begin
               mon_d_d = BAD_WORD;
               error_d = 1'b1;
            end else begin
               mon_d_d = mon_d_q;
               error_d = error_q | any_strobe_s;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; async reset drops any in-flight RAM strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mon_a_q     <= '0;
         mon_d_q     <= 32'h0000_0000;
         ram_addr_q  <= '0;
         ram_rd_q    <= 1'b0;
         ram_wr_q    <= 1'b0;
         ram_wdata_q <= 32'h0000_0000;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         oor_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mon_a_q     <= mon_a_d;
         mon_d_q     <= mon_d_d;
         ram_addr_q  <= ram_addr_d;
         ram_rd_q    <= ram_rd_d;
         ram_wr_q    <= ram_wr_d;
         ram_wdata_q <= ram_wdata_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         oor_q       <= oor_d;
      end
   end

   assign ram_addr      = ram_addr_q;
   assign ram_rd        = ram_rd_q;
   assign ram_wr        = ram_wr_q;
   assign ram_wdata     = ram_wdata_q;
   assign MonDReg       = mon_d_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2_oci_monitor_mem.sv
// Scoreboard bench for nios2_oci_monitor_mem: stimulus pushes expected RAM accesses and
// completions; a negedge monitor pops and compares them cycle-exactly.
module tb_nios2_oci_monitor_mem;

   localparam int DEPTH = 200;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [37:0] jdo = 38'd0;
   logic        ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
   logic [7:0]  ram_addr;
   logic        ram_rd, ram_wr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'd0;
   logic [31:0] mon_d;
   logic        ready, err;

   nios2_oci_monitor_mem #(.ADDR_W(8), .RAM_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
      .take_no_action_ocimem_a(tn_a),
      .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .MonDReg(mon_d), .monitor_ready(ready), .monitor_error(err)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; logic [7:0] addr; logic [31:0] data; } acc_t;
   typedef struct { int start; int done; logic [31:0] mond; logic err; } dn_t;

   acc_t rd_q[$];
   acc_t wr_q[$];
   dn_t  dn_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic ready_prev = 1'b0;

   logic [31:0] mem [256];
   logic [7:0]  exp_a = 8'd0;
   logic [31:0] exp_mond = 32'd0;
   logic        exp_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      if (ram_rd) ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: cycle %0d", name, cyc);
   endtask

   // Monitor: compares RAM strobes and completions against the queues
   always @(negedge clk) begin
      bit matched;
      matched = 1'b0;
      if (reset_n) begin
         if (ram_rd && ram_wr) flag("rd_wr_overlap");
         if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            flag("missing_ram_rd");
            void'(rd_q.pop_front());
         end
         if (ram_rd) begin
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
               chk("rd_addr", {24'd0, ram_addr}, {24'd0, rd_q[0].addr});
               void'(rd_q.pop_front());
            end else begin
               flag("unexpected_ram_rd");
            end
         end
         if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            flag("missing_ram_wr");
            void'(wr_q.pop_front());
         end
         if (ram_wr) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
               chk("wr_addr", {24'd0, ram_addr}, {24'd0, wr_q[0].addr});
               chk("wr_data", ram_wdata, wr_q[0].data);
               void'(wr_q.pop_front());
            end else begin
               flag("unexpected_ram_wr");
            end
         end
         if (dn_q.size() > 0) begin
            if (cyc >= dn_q[0].start && cyc < dn_q[0].done) begin
               chk("busy_ready", {31'd0, ready}, 32'd0);
            end else if (cyc == dn_q[0].done) begin
               chk("done_ready", {31'd0, ready}, 32'd1);
               chk("done_MonDReg", mon_d, dn_q[0].mond);
               chk("done_error", {31'd0, err}, {31'd0, dn_q[0].err});
               void'(dn_q.pop_front());
               matched = 1'b1;
            end else if (cyc > dn_q[0].done) begin
               flag("missed_completion");
               void'(dn_q.pop_front());
            end
         end
         if (ready && !ready_prev && !matched) flag("spurious_ready");
         ready_prev = ready;
      end else begin
         ready_prev = 1'b0;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
      jdo = j; ta_a = a; ta_b = b; tn_a = n;
      @(posedge clk);
      #1;
      ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0; jdo = 38'd0;
   endtask

   task automatic exp_read(input int k, input logic [7:0] addr, input logic [31:0] data,
                           input bit collide);
      if (int'(addr) < DEPTH) begin
         rd_q.push_back('{k + 1, addr, 32'd0});
         exp_mond = data;
      end else begin
         exp_err  = 1'b1;
         exp_mond = 32'hDEADDEAD;
      end
      if (collide) exp_err = 1'b1;
      dn_q.push_back('{k + 1, k + 3, exp_mond, exp_err});
   endtask

   task automatic do_a(input logic [7:0] addr, input bit rd, input bit clr,
                       input logic [31:0] data, input bit also_b, input bit collide);
      logic [37:0] j;
      int k;
      k = cyc;
      exp_a = addr;
      if (clr) exp_err = 1'b0;
      if (rd) exp_read(k, addr, data, collide);
      else dn_q.push_back('{k + 1, k + 1, exp_mond, exp_err});
      j = 38'd0;
      j[35] = clr;
      j[34] = rd;
      j[24:17] = addr;
      pulse(1'b1, also_b, 1'b0, j);
   endtask

   task automatic do_b(input logic [31:0] data);
      logic [37:0] j;
      int k;
      k = cyc;
      if (int'(exp_a) < DEPTH) begin
         wr_q.push_back('{k + 1, exp_a, data});
      end else begin
         exp_err  = 1'b1;
         exp_mond = 32'hDEADDEAD;
      end
      dn_q.push_back('{k + 1, k + 2, exp_mond, exp_err});
      exp_a = exp_a + 8'd1;
      j = 38'd0;
      j[34:3] = data;
      pulse(1'b0, 1'b1, 1'b0, j);
   endtask

   task automatic do_n(input logic [31:0] data);
      int k;
      k = cyc;
      exp_a = exp_a + 8'd1;
      exp_read(k, exp_a, data, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 38'd0);
   endtask

   initial begin
      logic [37:0] jc;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[8'h10] = 32'hCAFE0001;
      mem[8'h00] = 32'hA5A50000;
      mem[8'hC7] = 32'hC7C7C7C7;
      mem[8'h20] = 32'h11111111;
      mem[8'h30] = 32'h30303030;
      mem[8'h31] = 32'h31313131;

      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      #1;
      chk("rst_MonDReg", mon_d, 32'd0);
      chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
      chk("rst_ram_rd", {31'd0, ram_rd}, 32'd0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_error", {31'd0, err}, 32'd0);
      idle(1);

      do_a(8'h10, 1'b1, 1'b0, 32'hCAFE0001, 1'b0, 1'b0); idle(3);
      do_b(32'h12345678); idle(3);
      do_b(32'h0000BEEF); idle(3);
      do_a(8'h10, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0); idle(3);
      do_n(32'h0000BEEF); idle(3);

      do_a(8'hFF, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0); idle(2);
      do_n(32'hA5A50000); idle(3);

      do_a(8'hC7, 1'b1, 1'b0, 32'hC7C7C7C7, 1'b0, 1'b0); idle(3);
      do_a(8'hC8, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); idle(3);
      do_a(8'h10, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0); idle(2);
      do_a(8'hC8, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0); idle(2);
      do_b(32'hFFFFFFFF); idle(3);
      do_a(8'h10, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0); idle(2);

      do_a(8'h10, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b1);
      idle(1);
      jc = 38'd0;
      jc[34:3] = 32'h55555555;
      pulse(1'b0, 1'b1, 1'b0, jc);
      idle(3);
      do_a(8'h10, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0); idle(2);

      do_a(8'h30, 1'b1, 1'b0, 32'h30303030, 1'b1, 1'b0); idle(3);
      do_n(32'h31313131); idle(3);

      do_a(8'h20, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0); idle(2);
      do_b(32'hFFFFFFFF);
      chk("wr_before_reset", {31'd0, ram_wr}, 32'd1);
      rd_q.delete(); wr_q.delete(); dn_q.delete();
      reset_n = 1'b0;
      #1;
      chk("reset_wr_drop", {31'd0, ram_wr}, 32'd0);
      chk("reset_rd_low", {31'd0, ram_rd}, 32'd0);
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_MonDReg", mon_d, 32'd0);
      exp_a = 8'd0; exp_mond = 32'd0; exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      idle(1);
      do_a(8'h20, 1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0); idle(3);

      idle(4);
      chk("rd_q_empty", rd_q.size(), 32'd0);
      chk("wr_q_empty", wr_q.size(), 32'd0);
      chk("dn_q_empty", dn_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
